// File: rtl/flip_flop_fifo_with_status.sv
`default_nettype none
// ============================================================================
// Module      : flip_flop_fifo_with_status
// Description : Flip-flop based synchronous FIFO for any depth >= 2, with
//               show-ahead read data, full-with-pop pass-through, occupancy
//               count and programmable almost-full / almost-empty flags.
//               Define FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module flip_flop_fifo_with_status #(
    parameter int WIDTH              = 8,
    parameter int DEPTH              = 10,
    parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             write_data,
    output logic [WIDTH-1:0]             read_data,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FIFO_ERROR_FLAGS_EN
    ,
    output logic                         overflow,
    output logic                         underflow
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    // Parameter legality is checked at elaboration time
    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("flip_flop_fifo_with_status: DEPTH must be >= 2");
        end
        if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
            $error("flip_flop_fifo_with_status: ALMOST_FULL_LEVEL must be in 1..DEPTH");
        end
        if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("flip_flop_fifo_with_status: ALMOST_EMPTY_LEVEL must be in 0..DEPTH-1");
        end
    endgenerate

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic               wr_circ_q, wr_circ_d;
    logic               rd_circ_q, rd_circ_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];

    logic w_ptr_eq;
    logic w_push_ok;
    logic w_pop_ok;

    // Advance a pointer by one, wrapping at DEPTH-1 and toggling its circle bit
    function automatic logic [c_ptr_w:0] f_advance(input logic [c_ptr_w-1:0] ptr,
                                                   input logic               circ);
        logic [c_ptr_w:0] res;
        if (ptr == c_ptr_w'(DEPTH - 1)) begin
            res = {~circ, {c_ptr_w{1'b0}}};
        end else begin
            res = {circ, ptr + c_ptr_w'(1)};
        end
        return res;
    endfunction

    // Status decodes; empty/full depend only on registered pointer state
    always_comb begin
        w_ptr_eq     = (wr_ptr_q == rd_ptr_q);
        empty        = w_ptr_eq & (wr_circ_q == rd_circ_q);
        full         = w_ptr_eq & (wr_circ_q != rd_circ_q);
        almost_empty = (count_q <= c_cnt_w'(ALMOST_EMPTY_LEVEL));
        almost_full  = (count_q >= c_cnt_w'(ALMOST_FULL_LEVEL));
        count        = count_q;
        read_data    = mem_q[rd_ptr_q];
        // A pop when full frees the head slot, so a push may reuse it
        w_pop_ok     = pop & ~empty;
        w_push_ok    = push & (~full | pop);
    end

    // Next-state for pointers, circle bits and occupancy count
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_circ_d = wr_circ_q;
        rd_ptr_d  = rd_ptr_q;
        rd_circ_d = rd_circ_q;
        count_d   = count_q;
        if (w_push_ok) begin
            {wr_circ_d, wr_ptr_d} = f_advance(wr_ptr_q, wr_circ_q);
        end
        if (w_pop_ok) begin
            {rd_circ_d, rd_ptr_d} = f_advance(rd_ptr_q, rd_circ_q);
        end
        if (w_push_ok && !w_pop_ok) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            count_d = count_q - c_cnt_w'(1);
        end
    end

    // Storage next-state: only the slot under the write pointer changes
    always_comb begin
        mem_d = mem_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = write_data;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            wr_circ_q <= 1'b0;
            rd_ptr_q  <= '0;
            rd_circ_q <= 1'b0;
            count_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_circ_q <= wr_circ_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_circ_q <= rd_circ_d;
            count_q   <= count_d;
        end
    end

    // Data storage is deliberately left unreset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef FIFO_ERROR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error detection; has no effect on data path or pointers
    always_comb begin
        overflow_d  = overflow_q | (push & full & ~pop);
        underflow_d = underflow_q | (pop & empty);
        overflow    = overflow_q;
        underflow   = underflow_q;
    end

    // Error flag registers, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_flip_flop_fifo_with_status.sv
`default_nettype none
// ============================================================================
// Module      : tb_flip_flop_fifo_with_status
// Description : Directed and randomised self-checking bench for the
//               flip_flop_fifo_with_status block (DEPTH=10, WIDTH=8,
//               almost_full at 8, almost_empty at 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flip_flop_fifo_with_status;

    localparam int c_w  = 8;
    localparam int c_d  = 10;
    localparam int c_af = 8;
    localparam int c_ae = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           push;
    logic           pop;
    logic [c_w-1:0] write_data;
    logic [c_w-1:0] read_data;
    logic           empty;
    logic           full;
    logic           almost_empty;
    logic           almost_full;
    logic [3:0]     count;
`ifdef FIFO_ERROR_FLAGS_EN
    logic           overflow;
    logic           underflow;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [c_w-1:0] r_model [$];

    flip_flop_fifo_with_status #(
        .WIDTH              (c_w),
        .DEPTH              (c_d),
        .ALMOST_FULL_LEVEL  (c_af),
        .ALMOST_EMPTY_LEVEL (c_ae)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .write_data   (write_data),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count)
`ifdef FIFO_ERROR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock with the given request; updates the reference queue
    task automatic cycle(input logic pu, input logic po, input logic [c_w-1:0] d);
        logic m_empty, m_full, pop_ok, push_ok;
        push       = pu;
        pop        = po;
        write_data = d;
        m_empty    = (r_model.size() == 0);
        m_full     = (r_model.size() == c_d);
        pop_ok     = po && !m_empty;
        push_ok    = pu && (!m_full || po);
        @(posedge clk);
        #1;
        if (pop_ok)  r_model.delete(0);
        if (push_ok) r_model.push_back(d);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Compare every status output and the head word against the queue model
    task automatic check_model(input string tag);
        int sz;
        sz = r_model.size();
        check_val({tag, ".count"}, 32'(count), 32'(sz));
        check_val({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check_val({tag, ".full"},  32'(full),  32'(sz == c_d));
        check_val({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= c_ae));
        check_val({tag, ".afull"},  32'(almost_full),  32'(sz >= c_af));
        if (sz > 0) check_val({tag, ".rdata"}, 32'(read_data), 32'(r_model[0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".count"},  32'(count), 32'd0);
        check_val({tag, ".empty"},  32'(empty), 32'd1);
        check_val({tag, ".full"},   32'(full),  32'd0);
        check_val({tag, ".aempty"}, 32'(almost_empty), 32'd1);
        check_val({tag, ".afull"},  32'(almost_full),  32'd0);
`ifdef FIFO_ERROR_FLAGS_EN
        check_val({tag, ".ovf"}, 32'(overflow),  32'd0);
        check_val({tag, ".unf"}, 32'(underflow), 32'd0);
`endif
    endtask

    initial begin
        rst        = 1'b1;
        push       = 1'b0;
        pop        = 1'b0;
        write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Fill 0x01..0x0A
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            check_val("fill.count", 32'(count), 32'(i));
            check_val("fill.afull", 32'(almost_full), 32'(i >= 8));
            check_val("fill.aempty", 32'(almost_empty), 32'(i <= 2));
            check_val("fill.full", 32'(full), 32'(i == 10));
            check_val("fill.empty", 32'(empty), 32'd0);
            check_val("fill.head", 32'(read_data), 32'h01);
        end

        // Push alone while full is dropped
        cycle(1'b1, 1'b0, 8'hFF);
        check_val("ovpush.count", 32'(count), 32'd10);
        check_val("ovpush.full", 32'(full), 32'd1);
        check_val("ovpush.head", 32'(read_data), 32'h01);
`ifdef FIFO_ERROR_FLAGS_EN
        check_val("ovpush.ovf", 32'(overflow), 32'd1);
        check_val("ovpush.unf", 32'(underflow), 32'd0);
`endif

        // Drain in order
        for (int i = 1; i <= 10; i++) begin
            check_val("drain.rdata", 32'(read_data), 32'(i));
            cycle(1'b0, 1'b1, 8'h00);
            check_val("drain.count", 32'(count), 32'(10 - i));
        end
        check_val("drain.empty", 32'(empty), 32'd1);

        // Refill, then push+pop while full for 12 cycles
        for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b0, 8'(i));
        for (int k = 0; k < 12; k++) begin
            check_val("pass.head", 32'(read_data), (k < 10) ? 32'(k + 1) : 32'hAA);
            cycle(1'b1, 1'b1, 8'hAA);
            check_val("pass.full", 32'(full), 32'd1);
            check_val("pass.count", 32'(count), 32'd10);
        end
        for (int i = 0; i < 10; i++) begin
            check_val("pass_drain.rdata", 32'(read_data), 32'hAA);
            cycle(1'b0, 1'b1, 8'h00);
            check_model("pass_drain");
        end
        check_val("pass_drain.empty", 32'(empty), 32'd1);

        // Pop + push while empty: pop ignored, no bypass
        cycle(1'b1, 1'b1, 8'h55);
        check_val("emptypp.count", 32'(count), 32'd1);
        check_val("emptypp.rdata", 32'(read_data), 32'h55);
        check_val("emptypp.empty", 32'(empty), 32'd0);
`ifdef FIFO_ERROR_FLAGS_EN
        check_val("emptypp.unf", 32'(underflow), 32'd1);
        check_val("emptypp.ovf", 32'(overflow), 32'd1);
`endif
        cycle(1'b0, 1'b1, 8'h00);
        check_val("emptypp.drain", 32'(empty), 32'd1);

        // Random traffic against the queue model, push-heavy then pop-heavy
        for (int n = 0; n < 1000; n++) begin
            logic pu, po;
            if (n < 500) begin
                pu = ($urandom_range(0, 9) < 7);
                po = ($urandom_range(0, 9) < 4);
            end else begin
                pu = ($urandom_range(0, 9) < 4);
                po = ($urandom_range(0, 9) < 7);
            end
            cycle(pu, po, 8'($urandom));
            check_model("rand");
        end

        // Drain, then build up to 6 entries
        for (int i = 0; i < 12 && r_model.size() > 0; i++) cycle(1'b0, 1'b1, 8'h00);
        check_val("pre_rst.empty", 32'(empty), 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        check_model("pre_rst");

        // Asynchronous reset mid-burst, away from the clock edge
        push       = 1'b1;
        write_data = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        push = 1'b0;
        r_model.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'h33);
        check_val("post_rst.rdata", 32'(read_data), 32'h33);
        check_val("post_rst.count", 32'(count), 32'd1);
        check_model("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
